// File: rtl/sram_pkg.sv
// Shared constants, clear-FSM state type and bypass byte-merge for sram_array_dc.
package sram_pkg;

    localparam int MACRO_DEPTH     = 512;
    localparam int MACRO_WIDTH     = 32;
    localparam int MACRO_ADDR_BITS = 9;

    typedef enum logic [1:0] {
        RESET,
        CLEAR,
        READY
    } clr_state_e;

    function automatic logic [MACRO_WIDTH-1:0] byte_merge(
        input logic [MACRO_WIDTH-1:0]   mem_word,
        input logic [MACRO_WIDTH-1:0]   wr_word,
        input logic [MACRO_WIDTH/8-1:0] mask
    );
        logic [MACRO_WIDTH-1:0] r;
        r = mem_word;
        for (int i = 0; i < MACRO_WIDTH / 8; i++) begin
            if (mask[i]) r[8*i +: 8] = wr_word[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv
// Behavioural stand-in for the 1rw1r 32x512 macro: synchronous ports, byte mask,
// dout updated only on a read and held otherwise.
module sky130_sram_2kbyte_1rw1r_32x512_8 (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [8:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [8:0]  addr1,
    output logic [31:0] dout1
);

    logic [31:0] mem [512];

    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < 4; i++) begin
                    if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!csb1) dout1 <= mem[addr1];
    end

endmodule

// File: rtl/sram_bank_dc.sv
// One bank row of LANES macros sharing csb/addr; lane k owns data bits [32k+:32]
// and mask bits [4k+:4].
module sram_bank_dc
    import sram_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                         clk_i,
    input  logic                         csb0_i,
    input  logic                         web0_i,
    input  logic [LANES*4-1:0]           wmask0_i,
    input  logic [MACRO_ADDR_BITS-1:0]   addr0_i,
    input  logic [LANES*MACRO_WIDTH-1:0] din0_i,
    output logic [LANES*MACRO_WIDTH-1:0] dout0_o,
    input  logic                         csb1_i,
    input  logic [MACRO_ADDR_BITS-1:0]   addr1_i,
    output logic [LANES*MACRO_WIDTH-1:0] dout1_o
);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
            .clk0   (clk_i),
            .csb0   (csb0_i),
            .web0   (web0_i),
            .wmask0 (wmask0_i[4*k +: 4]),
            .addr0  (addr0_i),
            .din0   (din0_i[MACRO_WIDTH*k +: MACRO_WIDTH]),
            .dout0  (dout0_o[MACRO_WIDTH*k +: MACRO_WIDTH]),
            .clk1   (clk_i),
            .csb1   (csb1_i),
            .addr1  (addr1_i),
            .dout1  (dout1_o[MACRO_WIDTH*k +: MACRO_WIDTH])
        );
    end

endmodule

// File: rtl/sram_array_dc.sv
// BANKS x LANES dual-port SRAM array: 2-cycle registered reads with rvalid strobes and
// a port-0-write to port-1-read bypass. SRAM_CLEAR_EN adds a post-reset zero-fill FSM.
//
// state | meaning
// RESET | in/just out of reset, row 0 being zeroed
// CLEAR | zeroing rows 1..511 of every macro, one per cycle
// READY | array accepts requests
module sram_array_dc
    import sram_pkg::*;
#(
    parameter int SIZE_IN_WORDS = 1024,
    parameter int WORD_SIZE     = 32,
    parameter int ADDR_LEN      = $clog2(SIZE_IN_WORDS),
    parameter int BANKS         = SIZE_IN_WORDS / MACRO_DEPTH,
    parameter int LANES         = WORD_SIZE / MACRO_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   ready,
    input  logic                   nce0,
    input  logic                   nwe0,
    input  logic [ADDR_LEN-1:0]    addr0,
    input  logic [WORD_SIZE-1:0]   wdata0,
    input  logic [WORD_SIZE/8-1:0] wmask0,
    output logic [WORD_SIZE-1:0]   rdata0,
    output logic                   rvalid0,
    input  logic                   nce1,
    input  logic [ADDR_LEN-1:0]    addr1,
    output logic [WORD_SIZE-1:0]   rdata1,
    output logic                   rvalid1
);

    localparam int BSEL_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int MASK_W = WORD_SIZE / 8;

    logic                       acc0, rd0, wr0, rd1, coll;
    logic [BSEL_W-1:0]          bank0, bank1;
    logic                       clr_active;
    logic [MACRO_ADDR_BITS-1:0] clr_row;

    logic                       web0_m;
    logic [MASK_W-1:0]          wmask0_m;
    logic [MACRO_ADDR_BITS-1:0] row0_m;
    logic [WORD_SIZE-1:0]       din0_m;
    logic [WORD_SIZE-1:0]       dout0_b [BANKS];
    logic [WORD_SIZE-1:0]       dout1_b [BANKS];

    logic                       rd0_q, rd1_q;
    logic [BSEL_W-1:0]          bank0_q, bank1_q;
    logic [MASK_W-1:0]          cmask_q;
    logic [WORD_SIZE-1:0]       cdata_q;
    logic                       rvalid0_q, rvalid1_q;
    logic [WORD_SIZE-1:0]       rdata0_q, rdata1_q, rdata1_d;

`ifdef SRAM_CLEAR_EN
    clr_state_e                 state_q;
    logic [MACRO_ADDR_BITS-1:0] cnt_q;
    logic                       ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                RESET: begin
                    state_q <= CLEAR;
                    cnt_q   <= MACRO_ADDR_BITS'(1);
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == MACRO_ADDR_BITS'(MACRO_DEPTH - 1)) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: ;
                default: begin
                    state_q <= RESET;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign clr_active = (state_q != READY);
    assign clr_row    = cnt_q;
`else
    assign ready      = 1'b1;
    assign clr_active = 1'b0;
    assign clr_row    = '0;
`endif

    if (BANKS > 1) begin : g_bsel
        assign bank0 = addr0[ADDR_LEN-1:MACRO_ADDR_BITS];
        assign bank1 = addr1[ADDR_LEN-1:MACRO_ADDR_BITS];
    end else begin : g_bsel_one
        assign bank0 = '0;
        assign bank1 = '0;
    end

    assign acc0 = ready & ~nce0;
    assign rd0  = acc0 & nwe0;
    assign wr0  = acc0 & ~nwe0;
    assign rd1  = ready & ~nce1;
    assign coll = wr0 & rd1 & (addr0 == addr1);

    // The clear sequencer owns port 0 of every macro until READY.
    assign web0_m   = clr_active ? 1'b0 : nwe0;
    assign wmask0_m = clr_active ? {MASK_W{1'b1}} : wmask0;
    assign row0_m   = clr_active ? clr_row : addr0[MACRO_ADDR_BITS-1:0];
    assign din0_m   = clr_active ? '0 : wdata0;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        sram_bank_dc #(.LANES(LANES)) u_bank (
            .clk_i    (clk),
            .csb0_i   (~(clr_active | (acc0 & (bank0 == BSEL_W'(b))))),
            .web0_i   (web0_m),
            .wmask0_i (wmask0_m),
            .addr0_i  (row0_m),
            .din0_i   (din0_m),
            .dout0_o  (dout0_b[b]),
            .csb1_i   (~(rd1 & (bank1 == BSEL_W'(b)))),
            .addr1_i  (addr1[MACRO_ADDR_BITS-1:0]),
            .dout1_o  (dout1_b[b])
        );
    end

    // Masked bytes come from the captured write data, so the macro's
    // read-during-write value is never selected for them.
    always_comb begin
        rdata1_d = '0;
        for (int k = 0; k < LANES; k++) begin
            rdata1_d[MACRO_WIDTH*k +: MACRO_WIDTH] = byte_merge(
                dout1_b[bank1_q][MACRO_WIDTH*k +: MACRO_WIDTH],
                cdata_q[MACRO_WIDTH*k +: MACRO_WIDTH],
                cmask_q[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_q     <= 1'b0;
            rd1_q     <= 1'b0;
            bank0_q   <= '0;
            bank1_q   <= '0;
            cmask_q   <= '0;
            cdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rd0_q     <= rd0;
            rd1_q     <= rd1;
            bank0_q   <= bank0;
            bank1_q   <= bank1;
            cmask_q   <= coll ? wmask0 : '0;
            if (coll) cdata_q <= wdata0;
            rvalid0_q <= rd0_q;
            rvalid1_q <= rd1_q;
            if (rd0_q) rdata0_q <= dout0_b[bank0_q];
            if (rd1_q) rdata1_q <= rdata1_d;
        end
    end

    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_sram_array_dc.sv
// Scoreboard bench for sram_array_dc (2048 x 64): randomized and directed traffic
// against a word-array reference; zero-fill checks when SRAM_CLEAR_EN is defined.
module tb_sram_array_dc;

    localparam int SIZE = 2048;
    localparam int WS   = 64;
    localparam int AL   = 11;
    localparam int MW   = WS / 8;

    typedef struct {
        logic [WS-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ready;
    logic          nce0, nwe0, nce1;
    logic [AL-1:0] addr0, addr1;
    logic [WS-1:0] wdata0, rdata0, rdata1;
    logic [MW-1:0] wmask0;
    logic          rvalid0, rvalid1;

    exp_t          q0[$];
    exp_t          q1[$];
    exp_t          e0, e1;
    logic [WS-1:0] model [SIZE];
    logic [WS-1:0] last0 = '0;
    logic [WS-1:0] last1 = '0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    bit            tb_ready = 1'b1;

    sram_array_dc #(
        .SIZE_IN_WORDS (SIZE),
        .WORD_SIZE     (WS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ready   (ready),
        .nce0    (nce0),
        .nwe0    (nwe0),
        .addr0   (addr0),
        .wdata0  (wdata0),
        .wmask0  (wmask0),
        .rdata0  (rdata0),
        .rvalid0 (rvalid0),
        .nce1    (nce1),
        .addr1   (addr1),
        .rdata1  (rdata1),
        .rvalid1 (rvalid1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Monitor: every returned read must match the oldest outstanding expectation
    // exactly two cycles after issue; between returns the data must hold.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            last0 = '0;
            last1 = '0;
        end else begin
            if (rvalid0) begin
                if (q0.size() == 0) chk("rvalid0_unexpected", rvalid0, 0);
                else begin
                    e0 = q0.pop_front();
                    chk("rdata0", rdata0, e0.data);
                    chk("latency0", cyc, e0.cyc + 2);
                    last0 = e0.data;
                end
            end else chk("rdata0_hold", rdata0, last0);
            if (rvalid1) begin
                if (q1.size() == 0) chk("rvalid1_unexpected", rvalid1, 0);
                else begin
                    e1 = q1.pop_front();
                    chk("rdata1", rdata1, e1.data);
                    chk("latency1", cyc, e1.cyc + 2);
                    last1 = e1.data;
                end
            end else chk("rdata1_hold", rdata1, last1);
        end
    end

    // One cycle of stimulus, called at a falling edge; the model is a plain word
    // array and a same-cycle port-1 read observes the bytes just written.
    task automatic op(input logic n0, input logic w0, input logic [AL-1:0] a0,
                      input logic [WS-1:0] d0, input logic [MW-1:0] m0,
                      input logic n1, input logic [AL-1:0] a1);
        exp_t t;
        nce0 = n0; nwe0 = w0; addr0 = a0; wdata0 = d0; wmask0 = m0;
        nce1 = n1; addr1 = a1;
        if (tb_ready) begin
            if (!n0 && !w0) begin
                for (int i = 0; i < MW; i++)
                    if (m0[i]) model[a0][8*i +: 8] = d0[8*i +: 8];
            end
            if (!n0 && w0) begin
                t.data = model[a0]; t.cyc = cyc; q0.push_back(t);
            end
            if (!n1) begin
                t.data = model[a1]; t.cyc = cyc; q1.push_back(t);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
    endtask

    function automatic logic [AL-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return AL'($urandom_range(0, SIZE - 1));
            1:       return AL'($urandom_range(508, 515));
            default: return AL'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic wait_ready(input int expn, input string name);
        int n = 0;
        while (!ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, n, expn);
        @(negedge clk);
    endtask

    initial begin
        nce0 = 1'b1; nwe0 = 1'b1; addr0 = '0; wdata0 = '0; wmask0 = '0;
        nce1 = 1'b1; addr1 = '0;
        repeat (3) @(negedge clk);
        chk("reset_rvalid0", rvalid0, 0);
        chk("reset_rvalid1", rvalid1, 0);
        chk("reset_rdata0", rdata0, 0);
        chk("reset_rdata1", rdata1, 0);
`ifdef SRAM_CLEAR_EN
        chk("reset_ready", ready, 0);
        rst_n = 1'b1;
        wait_ready(512, "clear_ready_cycles");
        for (int a = 0; a < SIZE; a++) model[a] = '0;
        for (int i = 0; i < 16; i++)
            op(1'b0, 1'b1, pick_addr(), '0, '0, 1'b0, pick_addr());
`else
        chk("reset_ready", ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        for (int a = 0; a < SIZE; a++)
            op(1'b0, 1'b0, AL'(a), {$urandom, $urandom}, '1, 1'b1, '0);

        // Wide word across a non-zero bank, neighbour in bank 0 untouched.
        op(1'b0, 1'b0, AL'('h5FF), 64'h1122334455667788, '1, 1'b1, '0);
        op(1'b1, 1'b1, '0, '0, '0, 1'b0, AL'('h5FF));
        op(1'b1, 1'b1, '0, '0, '0, 1'b0, AL'('h1FF));
        idle(3);

        // Bank boundary, pipelined port-0 reads.
        op(1'b0, 1'b0, AL'(511), 64'hA, '1, 1'b1, '0);
        op(1'b0, 1'b0, AL'(512), 64'hB, '1, 1'b1, '0);
        op(1'b0, 1'b1, AL'(511), '0, '0, 1'b1, '0);
        op(1'b0, 1'b1, AL'(512), '0, '0, 1'b1, '0);
        op(1'b0, 1'b1, AL'(511), '0, '0, 1'b1, '0);
        idle(3);

        // Collision with a partial mask, then both ports reading the same word.
        op(1'b0, 1'b0, AL'(7), 64'hCAFEF00D_DEADBEEF, '1, 1'b1, '0);
        op(1'b0, 1'b0, AL'(7), 64'h00000000_12345678, 8'h05, 1'b0, AL'(7));
        op(1'b0, 1'b1, AL'(7), '0, '0, 1'b0, AL'(7));
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            op(kind == 0, kind != 2, pick_addr(), {$urandom, $urandom}, MW'($urandom),
               $urandom_range(0, 3) == 0, pick_addr());
        end
        idle(4);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

`ifdef SRAM_CLEAR_EN
        // Array now holds random data; reset, abort the clear at row 200, restart.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tb_ready = 1'b0;
        for (int i = 0; i < 200; i++)
            op(1'b0, 1'b1, pick_addr(), '0, '0, 1'b0, pick_addr());
        chk("ready_mid_clear", ready, 0);
        nce0 = 1'b1; nce1 = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(512, "restart_ready_cycles");
        tb_ready = 1'b1;
        for (int a = 0; a < SIZE; a++) model[a] = '0;
        for (int i = 0; i < 40; i++)
            op(1'b0, 1'b1, pick_addr(), '0, '0, 1'b0, AL'($urandom_range(0, SIZE - 1)));
        idle(4);
        chk("q0_drained_clear", q0.size(), 0);
        chk("q1_drained_clear", q1.size(), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
